mux_pipe_n: RTL and testbench

MUX_PIPE_N -- requirements
Module: mux_pipe_n

---
 rtl/mux_pipe_n_if.sv | 27 ++
 rtl/mux_pipe_n.sv | 114 +++++++++++
 tb/tb_mux_pipe_n.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_pipe_n_if.sv
// mux_pipe_n_if: handshake bundle for mux_pipe_n.
// master drives in_data/sel/in_valid/out_ready/flush; slave answers with in_ready/out_data/out_valid.
interface mux_pipe_n_if #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 2
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    flush;

  modport master (
    output in_data, sel, in_valid, out_ready, flush,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, sel, in_valid, out_ready, flush,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/mux_pipe_n.sv
// mux_pipe_n: N-way mux into a two-entry (main + skid) valid/ready pipeline stage.
// Ports: clk, rst (async high), bus (mux_pipe_n_if.slave), sel_err only with MUX_PIPE_N_SELERR_EN.
module mux_pipe_n #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 2
) (
  input  logic          clk,
  input  logic          rst,
  mux_pipe_n_if.slave   bus
`ifdef MUX_PIPE_N_SELERR_EN
  ,
  output logic          sel_err
`endif
);
  localparam int SEL_W = $clog2(NUM_IN);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_pick;
  logic             w_in;
  logic             w_out;
`ifdef MUX_PIPE_N_SELERR_EN
  logic             w_oor;
  logic             r_sel_err;
`endif

  assign w_in  = bus.in_valid && bus.in_ready;
  assign w_out = bus.out_valid && bus.out_ready;

  // Unmatched selects fall back to channel 0 unless error checking
  // is built in, in which case they yield zero.
  always_comb begin
    w_pick = bus.in_data[WIDTH-1:0];
`ifdef MUX_PIPE_N_SELERR_EN
    w_oor = 1'b1;
`endif
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        w_pick = bus.in_data[k*WIDTH +: WIDTH];
`ifdef MUX_PIPE_N_SELERR_EN
        w_oor = 1'b0;
`endif
      end
    end
`ifdef MUX_PIPE_N_SELERR_EN
    if (w_oor) w_pick = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.flush) begin
      w_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_in) w_next = ONE;
        ONE: begin
          if (w_in && !w_out)      w_next = FULL;
          else if (!w_in && w_out) w_next = EMPTY;
        end
        FULL:  if (w_out) w_next = ONE;
        default: w_next = EMPTY;
      endcase
    end
  end

  // in_ready depends on state only, so no out_ready -> in_ready path.
  always_comb begin
    bus.in_ready  = (r_state != FULL);
    bus.out_valid = (r_state != EMPTY);
  end

  assign bus.out_data = r_main;

  // Flush leaves data contents alone; only the state is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (!bus.flush) begin
      case (r_state)
        EMPTY: if (w_in) r_main <= w_pick;
        ONE: begin
          if (w_in && w_out) r_main <= w_pick;
          else if (w_in)     r_skid <= w_pick;
        end
        FULL:  if (w_out) r_main <= r_skid;
        default: ;
      endcase
    end
  end

`ifdef MUX_PIPE_N_SELERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             r_sel_err <= 1'b0;
    else if (w_in && w_oor && !bus.flush) r_sel_err <= 1'b1;
  end

  assign sel_err = r_sel_err;
`endif
endmodule

// File: tb/tb_mux_pipe_n.sv
// tb_mux_pipe_n: scoreboard bench for mux_pipe_n.
// DUT a: WIDTH=5 NUM_IN=4; DUT b: WIDTH=5 NUM_IN=3 for out-of-range selects.
module tb_mux_pipe_n;
  localparam int W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_pipe_n_if #(.WIDTH(W), .NUM_IN(4)) ifa ();
  mux_pipe_n_if #(.WIDTH(W), .NUM_IN(3)) ifb ();

`ifdef MUX_PIPE_N_SELERR_EN
  logic sel_err_a;
  logic sel_err_b;
`endif

  mux_pipe_n #(.WIDTH(W), .NUM_IN(4)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
`ifdef MUX_PIPE_N_SELERR_EN
    ,
    .sel_err (sel_err_a)
`endif
  );

  mux_pipe_n #(.WIDTH(W), .NUM_IN(3)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
`ifdef MUX_PIPE_N_SELERR_EN
    ,
    .sel_err (sel_err_b)
`endif
  );

  int n_chk = 0;
  int n_err = 0;
  int n_out = 0;
  logic [W-1:0] q[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref4(input logic [4*W-1:0] d,
                                        input logic [1:0] s);
    case (s)
      2'd0:    return d[4:0];
      2'd1:    return d[9:5];
      2'd2:    return d[14:10];
      default: return d[19:15];
    endcase
  endfunction

  // Scoreboard: an item leaves at the next edge if out_valid&&out_ready,
  // and enters if in_valid&&in_ready; flush discards everything held.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifa.flush) begin
        q.delete();
      end else begin
        if (ifa.out_valid && ifa.out_ready) begin
          n_out++;
          if (q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
          else chk("sb_data", 32'(ifa.out_data), 32'(q.pop_front()));
        end
        if (ifa.in_valid && ifa.in_ready)
          q.push_back(ref4(ifa.in_data, ifa.sel));
      end
    end
  end

  always @(posedge rst) q.delete();

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_two(input logic [W-1:0] a, input logic [W-1:0] b);
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.sel       = 2'd0;
    ifa.in_data   = {15'd0, a};
    step();
    ifa.sel       = 2'd2;
    ifa.in_data   = {5'd0, b, 10'd0};
    step();
    ifa.in_valid  = 1'b0;
  endtask

  int base;
  int bubbles;
  logic [W-1:0] exp_b;

  initial begin
    ifa.in_data = '0; ifa.sel = '0; ifa.in_valid = 1'b0;
    ifa.out_ready = 1'b0; ifa.flush = 1'b0;
    ifb.in_data = '0; ifb.sel = '0; ifb.in_valid = 1'b0;
    ifb.out_ready = 1'b0; ifb.flush = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("rst_out_data", 32'(ifa.out_data), 32'd0);
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("rst_in_ready", 32'(ifa.in_ready), 32'd1);

    // single item, sel=3
    step();
    ifa.in_data   = {5'h1F, 5'h03, 5'h02, 5'h01};
    ifa.sel       = 2'd3;
    ifa.in_valid  = 1'b1;
    ifa.out_ready = 1'b1;
    step();
    ifa.in_valid = 1'b0;
    @(negedge clk);
    chk("one_out_valid", 32'(ifa.out_valid), 32'd1);
    chk("one_out_data", 32'(ifa.out_data), 32'h1F);
    step();
    @(negedge clk);
    chk("one_drained", 32'(ifa.out_valid), 32'd0);

    // backpressure: A then B held, then drained in order
    step();
    fill_two(5'h0A, 5'h15);
    @(negedge clk);
    chk("full_in_ready", 32'(ifa.in_ready), 32'd0);
    chk("full_out_data", 32'(ifa.out_data), 32'h0A);
    step();
    @(negedge clk);
    chk("full_hold", 32'(ifa.out_data), 32'h0A);
    base = n_out;
    ifa.out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("full_second", 32'(ifa.out_data), 32'h15);
    step();
    @(negedge clk);
    chk("full_count", 32'(n_out - base), 32'd2);
    chk("full_empty", 32'(ifa.out_valid), 32'd0);

    // 16-item stream with random select
    base = n_out;
    bubbles = 0;
    for (int i = 0; i <= 16; i++) begin
      step();
      if (i < 16) begin
        ifa.in_valid = 1'b1;
        ifa.in_data  = 20'($urandom);
        ifa.sel      = 2'($urandom_range(0, 3));
      end else begin
        ifa.in_valid = 1'b0;
      end
      @(negedge clk);
      if (i > 0 && !ifa.out_valid) bubbles++;
      if (i < 16 && !ifa.in_ready) bubbles++;
    end
    step();
    @(negedge clk);
    chk("stream_bubbles", 32'(bubbles), 32'd0);
    chk("stream_count", 32'(n_out - base), 32'd16);
    chk("stream_q_empty", 32'(q.size()), 32'd0);

    // flush from FULL with simultaneous in and out
    step();
    fill_two(5'h07, 5'h09);
    ifa.flush     = 1'b1;
    ifa.in_valid  = 1'b1;
    ifa.out_ready = 1'b1;
    step();
    ifa.flush    = 1'b0;
    ifa.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("flush_in_ready", 32'(ifa.in_ready), 32'd1);
    chk("flush_q", 32'(q.size()), 32'd0);

    // async reset while holding one item
    ifa.out_ready = 1'b0;
    step();
    ifa.in_valid = 1'b1;
    ifa.sel      = 2'd1;
    ifa.in_data  = {10'd0, 5'h13, 5'd0};
    step();
    ifa.in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 32'(ifa.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(ifa.out_valid), 32'd0);
    chk("async_rst_data", 32'(ifa.out_data), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", 32'(ifa.in_ready), 32'd1);

    // out-of-range select on a 3-channel instance
    ifb.in_data   = {5'h07, 5'h0A, 5'h15};
    ifb.sel       = 2'd3;
    ifb.in_valid  = 1'b1;
    ifb.out_ready = 1'b0;
    step();
    ifb.in_valid = 1'b0;
`ifdef MUX_PIPE_N_SELERR_EN
    exp_b = 5'h00;
`else
    exp_b = 5'h15;
`endif
    @(negedge clk);
    chk("oor_valid", 32'(ifb.out_valid), 32'd1);
    chk("oor_data", 32'(ifb.out_data), 32'(exp_b));
`ifdef MUX_PIPE_N_SELERR_EN
    chk("oor_sel_err", 32'(sel_err_b), 32'd1);
    chk("inrange_sel_err_a", 32'(sel_err_a), 32'd0);
`endif
    ifb.out_ready = 1'b1;
    ifb.sel       = 2'd1;
    ifb.in_valid  = 1'b1;
    step();
    ifb.in_valid = 1'b0;
    @(negedge clk);
    chk("b_sel1_data", 32'(ifb.out_data), 32'h0A);
`ifdef MUX_PIPE_N_SELERR_EN
    chk("sel_err_sticky", 32'(sel_err_b), 32'd1);
`endif
    step();
    @(negedge clk);
    chk("b_drained", 32'(ifb.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
